// File: rtl/led_pattern_sequencer.sv
// Display scheduler for the memory game: plays the first N entries of a small
// pattern memory as one-hot LED flashes, each followed by a dark gap.
module led_pattern_sequencer #(
    parameter int CLKS_ON  = 25000000,
    parameter int CLKS_OFF = 12500000,
    parameter int DEPTH    = 8
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic                       i_Wr_En,
    input  logic [$clog2(DEPTH)-1:0]   i_Wr_Addr,
    input  logic [1:0]                 i_Wr_Data,
    input  logic                       i_Start,
    input  logic [$clog2(DEPTH+1)-1:0] i_Length,
    input  logic                       i_Abort,
    output logic [3:0]                 o_LED,
    output logic                       o_Busy,
    output logic                       o_Done,
    output logic [$clog2(DEPTH)-1:0]   o_Index
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int LEN_W   = $clog2(DEPTH + 1);
    localparam int CLK_MAX = (CLKS_ON > CLKS_OFF) ? CLKS_ON : CLKS_OFF;
    localparam int CNT_W   = (CLK_MAX > 1) ? $clog2(CLK_MAX) : 1;

    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(CLKS_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(CLKS_OFF - 1);
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [3:0] led_decode(input logic [1:0] code);
        logic [3:0] onehot;
        case (code)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] index_r;
    logic [IDX_W-1:0] index_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_nxt_s;
    logic [LEN_W-1:0] last_idx_s;
    logic [3:0]       led_r;
    logic             busy_r;
    logic             done_r;
    logic             wr_ok_s;
    logic             at_last_s;
    logic [1:0]       rd_code_s;
    logic [1:0]       mem_r [DEPTH];

    assign wr_ok_s    = i_Wr_En && !busy_r;
    assign last_idx_s = len_r - LEN_W'(1);
    assign at_last_s  = (LEN_W'(index_r) == last_idx_s);

    // Pattern memory: no reset so contents survive a reset or abort.
    always_ff @(posedge i_Clk) begin
        if (wr_ok_s) begin
            mem_r[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    // Next-state, index, cycle-counter and length selection.
    always_comb begin
        state_nxt_s = state_r;
        index_nxt_s = index_r;
        cnt_nxt_s   = cnt_r;
        len_nxt_s   = len_r;
        case (state_r)
            ST_IDLE: begin
                if (i_Start && (i_Length != LEN_W'(0))) begin
                    state_nxt_s = ST_SHOW;
                    index_nxt_s = IDX_W'(0);
                    cnt_nxt_s   = CNT_W'(0);
                    len_nxt_s   = (i_Length > DEPTH_LEN) ? DEPTH_LEN : i_Length;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHOW: begin
                if (cnt_r == ON_LAST) begin
                    state_nxt_s = ST_GAP;
                    cnt_nxt_s   = CNT_W'(0);
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_r == OFF_LAST) begin
                    cnt_nxt_s = CNT_W'(0);
                    if (at_last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SHOW;
                        index_nxt_s = index_r + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_W'(0);
            end
            default: begin
                state_nxt_s = ST_IDLE;
                index_nxt_s = IDX_W'(0);
                cnt_nxt_s   = CNT_W'(0);
            end
        endcase
        // Abort outranks every normal transition, including the step into DONE.
        if (i_Abort && (state_r != ST_IDLE)) begin
            state_nxt_s = ST_IDLE;
            index_nxt_s = IDX_W'(0);
            cnt_nxt_s   = CNT_W'(0);
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // A write landing on the entry about to be shown is forwarded so the first
    // flash reflects it without an extra cycle.
    always_comb begin
        rd_code_s = mem_r[index_nxt_s];
        if (wr_ok_s && (i_Wr_Addr == index_nxt_s)) begin
            rd_code_s = i_Wr_Data;
        end else begin
            rd_code_s = mem_r[index_nxt_s];
        end
    end

    // State register; outputs are registered from the upcoming state.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_r <= ST_IDLE;
            index_r <= IDX_W'(0);
            cnt_r   <= CNT_W'(0);
            len_r   <= LEN_W'(0);
            led_r   <= 4'b0000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            index_r <= index_nxt_s;
            cnt_r   <= cnt_nxt_s;
            len_r   <= len_nxt_s;
            led_r   <= (state_nxt_s == ST_SHOW) ? led_decode(rd_code_s) : 4'b0000;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign o_LED   = led_r;
    assign o_Busy  = busy_r;
    assign o_Done  = done_r;
    assign o_Index = index_r;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with short on/off times.
module tb_led_pattern_sequencer;

    localparam int CLKS_ON  = 4;
    localparam int CLKS_OFF = 2;
    localparam int DEPTH    = 8;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [1:0] wr_data;
    logic       start;
    logic [3:0] length;
    logic       abort_in;
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [2:0] index;

    int checks;
    int failures;

    led_pattern_sequencer #(
        .CLKS_ON (CLKS_ON),
        .CLKS_OFF(CLKS_OFF),
        .DEPTH   (DEPTH)
    ) dut (
        .i_Clk    (clk),
        .i_Rst    (rst),
        .i_Wr_En  (wr_en),
        .i_Wr_Addr(wr_addr),
        .i_Wr_Data(wr_data),
        .i_Start  (start),
        .i_Length (length),
        .i_Abort  (abort_in),
        .o_LED    (led),
        .o_Busy   (busy),
        .o_Done   (done),
        .o_Index  (index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input logic [2:0] a, input logic [1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [3:0] l);
        start = 1'b1; length = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({led, busy, done, index} !== 9'd0) begin
            failures++;
            $display("FAIL reset led=%b busy=%b done=%b index=%0d required all 0", led, busy, done, index);
        end
    endtask

    task automatic test_playback();
        logic [1:0] codes [4];
        logic [3:0] exp_led;
        logic       exp_busy, exp_done;
        codes[0] = 2'd3; codes[1] = 2'd0; codes[2] = 2'd2; codes[3] = 2'd1;
        for (int a = 0; a < 4; a++) write_mem(3'(a), codes[a]);
        pulse_start(4'd4);
        for (int c = 1; c <= 26; c++) begin
            int t;
            t = c - 1;
            exp_led  = 4'b0000;
            exp_busy = (c <= 25);
            exp_done = (c == 25);
            if (t < 24 && (t % 6) < 4) exp_led = 4'b0001 << codes[t / 6];
            checks++;
            if (led !== exp_led || busy !== exp_busy || done !== exp_done) begin
                failures++;
                $display("FAIL playback c=%0d led=%b busy=%b done=%b required led=%b busy=%b done=%b",
                         c, led, busy, done, exp_led, exp_busy, exp_done);
            end
            if (t < 24) begin
                checks++;
                if (index !== 3'(t / 6)) begin
                    failures++;
                    $display("FAIL playback_index c=%0d index=%0d required %0d", c, index, t / 6);
                end
            end
            tick();
        end
    endtask

    task automatic test_zero_and_clamp();
        logic [1:0] codes [8];
        logic [3:0] exp_led;
        int         dones;
        pulse_start(4'd0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (busy !== 1'b0 || led !== 4'b0000) begin
                failures++;
                $display("FAIL zero_len busy=%b led=%b required busy=0 led=0000", busy, led);
            end
            tick();
        end
        codes[0] = 2'd3; codes[1] = 2'd0; codes[2] = 2'd2; codes[3] = 2'd1;
        codes[4] = 2'd0; codes[5] = 2'd1; codes[6] = 2'd2; codes[7] = 2'd3;
        for (int a = 4; a < 8; a++) write_mem(3'(a), codes[a]);
        pulse_start(4'd15);
        dones = 0;
        for (int c = 1; c <= 50; c++) begin
            int t;
            t = c - 1;
            exp_led = 4'b0000;
            if (t < 48 && (t % 6) < 4) exp_led = 4'b0001 << codes[t / 6];
            if (done) dones++;
            checks++;
            if (led !== exp_led || done !== (c == 49) || busy !== (c <= 49)) begin
                failures++;
                $display("FAIL clamp c=%0d led=%b done=%b busy=%b required led=%b done=%b busy=%b",
                         c, led, done, busy, exp_led, (c == 49), (c <= 49));
            end
            tick();
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL clamp_done_count got=%0d required 1", dones);
        end
    endtask

    task automatic test_write_while_busy();
        pulse_start(4'd1);
        write_mem(3'd0, 2'd0);
        wait_idle("busy_write");
        pulse_start(4'd1);
        checks++;
        if (led !== 4'b1000) begin
            failures++;
            $display("FAIL busy_write_dropped led=%b required 1000", led);
        end
        wait_idle("busy_write_replay");
        tick();
    endtask

    task automatic test_abort();
        int dones;
        pulse_start(4'd4);
        for (int c = 1; c < 8; c++) tick();
        checks++;
        if (led !== 4'b0001 || index !== 3'd1) begin
            failures++;
            $display("FAIL abort_pre led=%b index=%0d required 0001 index 1", led, index);
        end
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        checks++;
        if (led !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort led=%b busy=%b done=%b required 0000 0 0", led, busy, done);
        end
        pulse_start(4'd4);
        checks++;
        if (led !== 4'b1000 || index !== 3'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart led=%b index=%0d busy=%b required 1000 0 1", led, index, busy);
        end
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) dones++;
            tick();
        end
        checks++;
        if (dones != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_restart_done dones=%0d busy=%b required 1 0", dones, busy);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(4'd4);
        for (int c = 1; c < 5; c++) tick();
        checks++;
        if (led !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_gap led=%b busy=%b required 0000 1", led, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({led, busy, done, index} !== 9'd0) begin
            failures++;
            $display("FAIL rst_mid led=%b busy=%b done=%b index=%0d required all 0", led, busy, done, index);
        end
        pulse_start(4'd4);
        checks++;
        if (led !== 4'b1000) begin
            failures++;
            $display("FAIL rst_replay_e0 led=%b required 1000", led);
        end
        for (int c = 1; c < 7; c++) tick();
        checks++;
        if (led !== 4'b0001) begin
            failures++;
            $display("FAIL rst_replay_e1 led=%b required 0001", led);
        end
        wait_idle("rst_replay");
        tick();
    endtask

    task automatic test_back_to_back();
        int dones;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 2'd2;
        start = 1'b1; length = 4'd1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        checks++;
        if (led !== 4'b0100 || busy !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_write led=%b busy=%b required 0100 1", led, busy);
        end
        dones = (done === 1'b1) ? 1 : 0;
        start = 1'b1; length = 4'd4;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) dones++;
            tick();
        end
        checks++;
        if (dones != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_while_busy dones=%0d busy=%b required 1 0", dones, busy);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 2'd0;
        start = 1'b0; length = 4'd0; abort_in = 1'b0;
        tick();
        test_reset();
        test_playback();
        test_zero_and_clamp();
        test_write_while_busy();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
